// File: rtl/snake_field_builder_if.sv
// Handshake and data bundle between the snake movement logic and snake_field_builder.
// The master modport is the upstream side; the slave modport is the builder.
interface snake_field_builder_if #(
  parameter int unsigned SIZE_X  = 10,
  parameter int unsigned SIZE_Y  = 10,
  parameter int unsigned CW      = 8,
  parameter int unsigned MAX_LEN = SIZE_X * SIZE_Y
);
  logic                          step;
  logic [15:0]                   length;
  logic [2*CW*MAX_LEN-1:0]       snake_xy;
  logic [CW-1:0]                 apple_x;
  logic [CW-1:0]                 apple_y;
  logic                          apple_valid;
  logic [SIZE_X*SIZE_Y-1:0]      block_map;
  logic                          busy;
  logic                          done;
  logic [2*SIZE_X*SIZE_Y-1:0]    field;
  logic [15:0]                   empty_cells;
  logic                          collision;
  logic                          out_of_range;

  modport master (
    output step, length, snake_xy, apple_x, apple_y, apple_valid, block_map,
    input  busy, done, field, empty_cells, collision, out_of_range
  );

  modport slave (
    input  step, length, snake_xy, apple_x, apple_y, apple_valid, block_map,
    output busy, done, field, empty_cells, collision, out_of_range
  );
endinterface

// File: rtl/snake_field_builder.sv
// Multi-cycle snake field builder: walls, snake segments, apple, then empty-cell count.
// Build option: SNAKE_FIELD_COLLIDE_EN enables the self/wall collision check and flag.
module snake_field_builder #(
  parameter int unsigned SIZE_X  = 10,
  parameter int unsigned SIZE_Y  = 10,
  parameter int unsigned CW      = 8,
  parameter int unsigned MAX_LEN = SIZE_X * SIZE_Y
) (
  input logic                  clk,
  input logic                  rst,
  snake_field_builder_if.slave bus
);

  localparam int unsigned N         = SIZE_X * SIZE_Y;
  localparam int unsigned AW        = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [15:0] LEN_MAX   = 16'(MAX_LEN);
  localparam logic [15:0] LAST_CELL = 16'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SNAKE,
    S_APPLE,
    S_COUNT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [N-1:0][1:0]                r_map;
  logic [N-1:0][1:0]                r_field;
  logic [15:0]                      r_len;
  logic [15:0]                      r_idx;
  logic [15:0]                      r_cnt;
  logic [15:0]                      r_empty;
  logic [CW-1:0]                    r_ax;
  logic [CW-1:0]                    r_ay;
  logic                             r_av;
  logic                             r_oor;
  logic                             r_out_oor;
`ifdef SNAKE_FIELD_COLLIDE_EN
  logic                             r_coll;
  logic                             r_out_coll;
`endif

  logic [MAX_LEN-1:0][1:0][CW-1:0]  w_segs;
  logic [CW-1:0]                    w_seg_x;
  logic [CW-1:0]                    w_seg_y;
  logic                             w_seg_in;
  logic [AW-1:0]                    w_seg_cell;
  logic                             w_seg_blocked;
  logic                             w_apple_in;
  logic [AW-1:0]                    w_apple_cell;
  logic                             w_apple_ok;
  logic                             w_cell_empty;
  logic [15:0]                      w_cnt_next;
  logic [15:0]                      w_len_sat;
  logic                             w_accept;
  logic                             w_last_seg;
  logic                             w_last_cell;
  logic                             w_busy;
  logic                             w_done;

  assign w_segs     = bus.snake_xy;
  assign w_seg_x    = w_segs[SW'(r_idx)][0];
  assign w_seg_y    = w_segs[SW'(r_idx)][1];
  assign w_seg_in   = (32'(w_seg_x) < SIZE_X) && (32'(w_seg_y) < SIZE_Y);
  assign w_seg_cell = AW'(32'(w_seg_y) * SIZE_X + 32'(w_seg_x));

  // No apple cell (10) exists during SNAKE, so one bit distinguishes the cases:
  // bit0 marks 01/11 (occupied), bit1 marks 11 (wall).
`ifdef SNAKE_FIELD_COLLIDE_EN
  assign w_seg_blocked = r_map[w_seg_cell][0];
`else
  assign w_seg_blocked = r_map[w_seg_cell][1];
`endif

  assign w_apple_in   = (32'(r_ax) < SIZE_X) && (32'(r_ay) < SIZE_Y);
  assign w_apple_cell = AW'(32'(r_ay) * SIZE_X + 32'(r_ax));
  assign w_apple_ok   = r_av && w_apple_in && (r_map[w_apple_cell] == 2'b00);

  assign w_cell_empty = (r_map[AW'(r_idx)] == 2'b00);
  assign w_cnt_next   = r_cnt + {15'd0, w_cell_empty};

  assign w_len_sat   = (32'(bus.length) > MAX_LEN) ? LEN_MAX : bus.length;
  assign w_accept    = bus.step && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last_seg  = (r_idx == (r_len - 16'd1));
  assign w_last_cell = (r_idx == LAST_CELL);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_done = (r_state == S_DONE);
        if (w_accept) w_next = (w_len_sat == 16'd0) ? S_APPLE : S_SNAKE;
        else          w_next = S_IDLE;
      end
      S_SNAKE: begin
        w_busy = 1'b1;
        if (w_last_seg) w_next = S_APPLE;
      end
      S_APPLE: begin
        w_busy = 1'b1;
        w_next = S_COUNT;
      end
      S_COUNT: begin
        w_busy = 1'b1;
        if (w_last_cell) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_map     <= '0;
      r_field   <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_empty   <= '0;
      r_ax      <= '0;
      r_ay      <= '0;
      r_av      <= 1'b0;
      r_oor     <= 1'b0;
      r_out_oor <= 1'b0;
`ifdef SNAKE_FIELD_COLLIDE_EN
      r_coll     <= 1'b0;
      r_out_coll <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_len <= w_len_sat;
            r_ax  <= bus.apple_x;
            r_ay  <= bus.apple_y;
            r_av  <= bus.apple_valid;
            for (int unsigned k = 0; k < N; k++) begin
              r_map[AW'(k)] <= {2{bus.block_map[AW'(k)]}};
            end
            r_idx <= '0;
            r_cnt <= '0;
            r_oor <= 1'b0;
`ifdef SNAKE_FIELD_COLLIDE_EN
            r_coll <= 1'b0;
`endif
          end
        end
        S_SNAKE: begin
          r_idx <= r_idx + 16'd1;
          if (!w_seg_in)          r_oor <= 1'b1;
          else if (!w_seg_blocked) r_map[w_seg_cell] <= 2'b01;
`ifdef SNAKE_FIELD_COLLIDE_EN
          else                     r_coll <= 1'b1;
`endif
        end
        S_APPLE: begin
          r_idx <= '0;
          if (w_apple_ok) r_map[w_apple_cell] <= 2'b10;
        end
        S_COUNT: begin
          r_idx <= r_idx + 16'd1;
          r_cnt <= w_cnt_next;
          // Publish on the last COUNT edge so results are already visible in the done cycle.
          if (w_last_cell) begin
            r_field   <= r_map;
            r_empty   <= w_cnt_next;
            r_out_oor <= r_oor;
`ifdef SNAKE_FIELD_COLLIDE_EN
            r_out_coll <= r_coll;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy         = w_busy;
  assign bus.done         = w_done;
  assign bus.field        = r_field;
  assign bus.empty_cells  = r_empty;
  assign bus.out_of_range = r_out_oor;
`ifdef SNAKE_FIELD_COLLIDE_EN
  assign bus.collision    = r_out_coll;
`else
  assign bus.collision    = 1'b0;
`endif

endmodule

// File: tb/tb_snake_field_builder.sv
// Self-checking bench for snake_field_builder: directed cases from the behaviour list,
// then randomized builds checked against a grid model of the field rules.
module tb_snake_field_builder;

  localparam int unsigned SX = 10;
  localparam int unsigned SY = 10;
  localparam int unsigned CW = 8;
  localparam int unsigned ML = SX * SY;
  localparam int unsigned N  = SX * SY;
  localparam int unsigned FW = 2 * N;
`ifdef SNAKE_FIELD_COLLIDE_EN
  localparam bit COLL_EN = 1'b1;
`else
  localparam bit COLL_EN = 1'b0;
`endif

  typedef logic [FW-1:0] vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  snake_field_builder_if #(.SIZE_X(SX), .SIZE_Y(SY), .CW(CW), .MAX_LEN(ML)) bus ();

  snake_field_builder #(.SIZE_X(SX), .SIZE_Y(SY), .CW(CW), .MAX_LEN(ML)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   vectors     = 0;
  int   miscompares = 0;

  int   seg_x [ML];
  int   seg_y [ML];
  int   len_in;
  int   ax, ay;
  bit   av;
  bit   blk [N];

  vec_t exp_field;
  int   exp_empty;
  bit   exp_coll;
  bit   exp_oor;
  int   exp_lat;

  task automatic check(input string tag, input vec_t got, input vec_t exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    len_in = 0;
    ax = 0; ay = 0; av = 1'b0;
    for (int i = 0; i < int'(ML); i++) begin
      seg_x[i] = int'($urandom_range(0, 255));
      seg_y[i] = int'($urandom_range(0, 255));
    end
    for (int k = 0; k < int'(N); k++) blk[k] = 1'b0;
  endtask

  task automatic push_inputs();
    bus.length      = 16'(len_in);
    bus.apple_x     = CW'(ax);
    bus.apple_y     = CW'(ay);
    bus.apple_valid = av;
    for (int i = 0; i < int'(ML); i++) begin
      bus.snake_xy[2*CW*i +: CW]    = CW'(seg_x[i]);
      bus.snake_xy[2*CW*i+CW +: CW] = CW'(seg_y[i]);
    end
    for (int k = 0; k < int'(N); k++) bus.block_map[k] = blk[k];
  endtask

  // Grid model: 0 empty, 1 snake, 2 apple, 3 wall.
  task automatic run_model();
    int g [SY][SX];
    int lsat;
    exp_coll = 1'b0;
    exp_oor  = 1'b0;
    for (int y = 0; y < int'(SY); y++)
      for (int x = 0; x < int'(SX); x++)
        g[y][x] = blk[y*SX + x] ? 3 : 0;
    lsat = (len_in > int'(ML)) ? int'(ML) : len_in;
    for (int i = 0; i < lsat; i++) begin
      if (seg_x[i] >= int'(SX) || seg_y[i] >= int'(SY)) exp_oor = 1'b1;
      else if (COLL_EN && (g[seg_y[i]][seg_x[i]] == 1 || g[seg_y[i]][seg_x[i]] == 3)) exp_coll = 1'b1;
      else if (g[seg_y[i]][seg_x[i]] != 3) g[seg_y[i]][seg_x[i]] = 1;
    end
    if (av && ax < int'(SX) && ay < int'(SY) && g[ay][ax] == 0) g[ay][ax] = 2;
    exp_empty = 0;
    exp_field = '0;
    for (int y = 0; y < int'(SY); y++)
      for (int x = 0; x < int'(SX); x++) begin
        if (g[y][x] == 0) exp_empty++;
        exp_field[2*(y*SX + x) +: 2] = 2'(g[y][x]);
      end
    exp_lat = lsat + int'(N) + 2;
  endtask

  // Raises step from the current point, waits (bounded) for done, checks results.
  // Returns at the negedge of the done cycle so a caller may chain back-to-back.
  task automatic run_build(input string name, input int pulse_at);
    int cyc;
    bit got_done;
    push_inputs();
    run_model();
    bus.step = 1'b1;
    @(posedge clk);
    #1 bus.step = 1'b0;
    cyc = 1;
    got_done = 1'b0;
    while (cyc < exp_lat + 20) begin
      @(negedge clk);
      if (cyc == 1) check({name, "_busy_start"}, vec_t'(bus.busy), vec_t'(1'b1));
      if (bus.done) begin
        got_done = 1'b1;
        break;
      end
      if (cyc == pulse_at) bus.step = 1'b1;
      @(posedge clk);
      #1 bus.step = 1'b0;
      cyc++;
    end
    check({name, "_done_seen"}, vec_t'(got_done), vec_t'(1'b1));
    check({name, "_latency"}, vec_t'(cyc), vec_t'(exp_lat));
    check({name, "_busy_done"}, vec_t'(bus.busy), vec_t'(1'b0));
    check({name, "_field"}, vec_t'(bus.field), exp_field);
    check({name, "_empty"}, vec_t'(bus.empty_cells), vec_t'(exp_empty));
    check({name, "_collision"}, vec_t'(bus.collision), vec_t'(exp_coll));
    check({name, "_oor"}, vec_t'(bus.out_of_range), vec_t'(exp_oor));
  endtask

  task automatic expect_no_done(input string name, input int ncyc);
    int seen;
    seen = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    check({name, "_extra_done"}, vec_t'(seen), vec_t'(0));
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_busy"}, vec_t'(bus.busy), vec_t'(1'b0));
    check({name, "_done"}, vec_t'(bus.done), vec_t'(1'b0));
    check({name, "_field"}, vec_t'(bus.field), vec_t'(0));
    check({name, "_empty"}, vec_t'(bus.empty_cells), vec_t'(0));
    check({name, "_collision"}, vec_t'(bus.collision), vec_t'(1'b0));
    check({name, "_oor"}, vec_t'(bus.out_of_range), vec_t'(1'b0));
  endtask

  task automatic set_basic();
    clear_inputs();
    len_in = 3;
    seg_x[0] = 2; seg_y[0] = 2;
    seg_x[1] = 3; seg_y[1] = 2;
    seg_x[2] = 4; seg_y[2] = 2;
  endtask

  initial begin
    vec_t held;
    rst      = 1'b1;
    bus.step = 1'b0;
    clear_inputs();
    push_inputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // Basic three-segment build
    set_basic();
    run_build("basic", 0);
    check("basic_empty97", vec_t'(bus.empty_cells), vec_t'(97));
    check("basic_cell23", vec_t'(bus.field[2*23 +: 2]), vec_t'(2'b01));
    held = exp_field;
    repeat (3) @(negedge clk);
    check("basic_hold", vec_t'(bus.field), held);

    // Apple placed in a free corner, then onto the snake (dropped)
    av = 1'b1; ax = 0; ay = 0;
    run_build("apple", 0);
    check("apple_cell0", vec_t'(bus.field[1:0]), vec_t'(2'b10));
    check("apple_empty96", vec_t'(bus.empty_cells), vec_t'(96));
    ax = 3; ay = 2;
    run_build("apple_drop", 0);
    check("apple_drop_empty97", vec_t'(bus.empty_cells), vec_t'(97));

    // Self-hit
    clear_inputs();
    len_in = 3;
    seg_x[0] = 5; seg_y[0] = 5;
    seg_x[1] = 5; seg_y[1] = 6;
    seg_x[2] = 5; seg_y[2] = 5;
    run_build("selfhit", 0);
    check("selfhit_coll", vec_t'(bus.collision), vec_t'(COLL_EN));
    check("selfhit_empty98", vec_t'(bus.empty_cells), vec_t'(98));

    // Head on a wall
    clear_inputs();
    blk[0] = 1'b1;
    len_in = 1; seg_x[0] = 0; seg_y[0] = 0;
    run_build("block", 0);
    check("block_cell0", vec_t'(bus.field[1:0]), vec_t'(2'b11));
    check("block_empty99", vec_t'(bus.empty_cells), vec_t'(99));

    // Out-of-range segment
    clear_inputs();
    len_in = 2;
    seg_x[0] = 10; seg_y[0] = 0;
    seg_x[1] = 1;  seg_y[1] = 1;
    run_build("range", 0);
    check("range_oor", vec_t'(bus.out_of_range), vec_t'(1'b1));
    check("range_empty99", vec_t'(bus.empty_cells), vec_t'(99));

    // step while busy is ignored; exactly one done
    set_basic();
    run_build("pulse", 5);
    expect_no_done("pulse", 120);

    // Back-to-back: second step raised in the done cycle
    set_basic();
    run_build("b2b_a", 0);
    av = 1'b1; ax = 9; ay = 9;
    run_build("b2b_b", 0);

    // Zero length and saturated length
    clear_inputs();
    run_build("len0", 0);
    check("len0_emptyN", vec_t'(bus.empty_cells), vec_t'(N));
    clear_inputs();
    len_in = 300;
    for (int i = 0; i < int'(ML); i++) begin
      seg_x[i] = int'($urandom_range(0, 11));
      seg_y[i] = int'($urandom_range(0, 11));
    end
    run_build("lensat", 0);

    // Reset in the middle of a rebuild
    set_basic();
    push_inputs();
    bus.step = 1'b1;
    @(posedge clk);
    #1 bus.step = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("abort");
    expect_no_done("abort", 150);

    // Randomized builds
    for (int t = 0; t < 12; t++) begin
      int span;
      clear_inputs();
      span   = ($urandom_range(0, 2) == 0) ? 2 : 11;
      len_in = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 100)) : int'($urandom_range(0, 15));
      for (int i = 0; i < len_in; i++) begin
        seg_x[i] = int'($urandom_range(0, span));
        seg_y[i] = int'($urandom_range(0, span));
      end
      for (int k = 0; k < int'(N); k++) blk[k] = ($urandom_range(0, 7) == 0);
      av = 1'(($urandom_range(0, 1)));
      ax = int'($urandom_range(0, 11));
      ay = int'($urandom_range(0, 11));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) @(negedge clk);
      run_build($sformatf("rand%0d", t), int'($urandom_range(0, 8)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
